// File: rtl/mw_add_seq.sv
// ---------------------------------------------------------------------------
// mw_add_seq -- multi-word add sequencer
//
// Builds a WIDTH*NWORDS-bit adder out of one narrow combinational adder
// (fa_nbit). The operand pair is latched on the accepting edge. The words
// are then fed to fa_nbit least-significant first, one per cycle. Each
// partial sum is registered, and the carry is chained to the next word.
//
// Parameters
//   WIDTH   word width; must equal the WIDTH of the attached fa_nbit
//   NWORDS  words per operand (>= 1); operand width OW = WIDTH*NWORDS
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      add request, accepted only while idle
//   a, b   in   OW     operands, sampled at the accepting edge
//   ci     in   1      carry into word 0, sampled at the accepting edge
//   busy   out  1      high while an add is in progress
//   done   out  1      one-cycle pulse: sum/co valid
//   sum    out  OW     result, held until the next done
//   co     out  1      carry out of the top word, held with sum
//   fa_a   out  WIDTH  current word of A to fa_nbit
//   fa_b   out  WIDTH  current word of B to fa_nbit
//   fa_ci  out  1      ci for word 0, otherwise the registered carry
//   fa_s   in   WIDTH  fa_nbit sum
//   fa_co  in   1      fa_nbit carry out
//   ovf    out  1      signed overflow, held with sum (only with MWADD_OVF_EN)
//
// Configuration macro: MWADD_OVF_EN adds the ovf output.
// ---------------------------------------------------------------------------
module mw_add_seq #(
    parameter int WIDTH  = 12,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH*NWORDS-1:0]   a,
    input  logic [WIDTH*NWORDS-1:0]   b,
    input  logic                      ci,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*NWORDS-1:0]   sum,
    output logic                      co,
    output logic [WIDTH-1:0]          fa_a,
    output logic [WIDTH-1:0]          fa_b,
    output logic                      fa_ci,
    input  logic [WIDTH-1:0]          fa_s,
    input  logic                      fa_co
`ifdef MWADD_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int OW = WIDTH * NWORDS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   a_reg;
    logic [OW-1:0]   b_reg;
    logic            ci_reg;
    logic            carry;
    logic [OW-1:0]   shadow;
    logic [OW-1:0]   merged;
    logic            last_word;

    // The adder sees only registered values. There is no path from
    // start, a or b to fa_*, so fa_nbit's delay starts at a clock edge.
    assign fa_a      = a_reg[idx*WIDTH +: WIDTH];
    assign fa_b      = b_reg[idx*WIDTH +: WIDTH];
    assign fa_ci     = (idx == '0) ? ci_reg : carry;
    assign last_word = (idx == IW'(NWORDS - 1));

    // Result shadow with the word currently leaving fa_nbit already
    // inserted. On the final word, sum loads this complete value.
    // NOTE: the full default assignment before the partial overwrite keeps
    // every bit assigned on every path, so no latch is inferred.
    always_comb begin
        merged = shadow;
        merged[idx*WIDTH +: WIDTH] = fa_s;
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register reads the values it had before this edge, whatever order
    // the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            ci_reg <= 1'b0;
            carry  <= 1'b0;
            shadow <= '0;
            sum    <= '0;
            co     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MWADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        ci_reg <= ci;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    shadow <= merged;
                    carry  <= fa_co;
                    if (last_word) begin
                        sum   <= merged;
                        co    <= fa_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
`ifdef MWADD_OVF_EN
                        // Signed overflow: both operands have the same sign,
                        // and the result sign differs from it.
                        ovf   <= (a_reg[OW-1] ~^ b_reg[OW-1]) &
                                 (merged[OW-1] ^ a_reg[OW-1]);
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
